kamacore_stage_id: RTL and testbench

KAMACORE_STAGE_ID -- requirements
Module: kamacore_stage_id

---
 rtl/kamacore_stage_id.sv | 155 +++++++++++++++
 tb/tb_kamacore_stage_id.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/kamacore_stage_id.sv
// Instruction-decode stage: field decode, 32-entry register file with write-through,
// load-use interlock, branch squash and a RUN/HALTED state machine feeding the ID/EX register.
module kamacore_stage_id #(
   parameter int CPU_WIDTH  = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CPU_WIDTH-1:0]  if_instr,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  if_valid,
   input  logic                  branch_valid,
   input  logic                  wb_we,
   input  logic [4:0]            wb_rd,
   input  logic [CPU_WIDTH-1:0]  wb_data,
   output logic                  stall_if,
   output logic                  halted,
   output logic                  ex_valid,
   output logic [5:0]            ex_op,
   output logic [4:0]            ex_rd,
   output logic [CPU_WIDTH-1:0]  ex_rs1_val,
   output logic [CPU_WIDTH-1:0]  ex_rs2_val,
   output logic [CPU_WIDTH-1:0]  ex_imm,
   output logic [ADDR_WIDTH-1:0] ex_pc,
   output logic                  ex_we,
   output logic                  ex_is_load,
   output logic                  ex_is_store,
   output logic                  ex_is_branch
);

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h03;
   localparam logic [5:0] OP_LW   = 6'h04;
   localparam logic [5:0] OP_SW   = 6'h05;
   localparam logic [5:0] OP_BEQ  = 6'h06;
   localparam logic [5:0] OP_HALT = 6'h3F;

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   typedef struct packed {
      logic                  valid;
      logic [5:0]            op;
      logic [4:0]            rd;
      logic [CPU_WIDTH-1:0]  rs1_val;
      logic [CPU_WIDTH-1:0]  rs2_val;
      logic [CPU_WIDTH-1:0]  imm;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  we;
      logic                  is_load;
      logic                  is_store;
      logic                  is_branch;
   } ex_t;

   state_t               state_q, state_d;
   ex_t                  ex_q, ex_d;
   logic [CPU_WIDTH-1:0] rf_q [32];

   logic [5:0]           op;
   logic [4:0]           rd, rs1, rs2;
   logic [CPU_WIDTH-1:0] imm_ext;
   logic                 known_op, uses_rs2, writes_rd, hazard;

   assign op      = if_instr[31:26];
   assign rd      = if_instr[25:21];
   assign rs1     = if_instr[20:16];
   assign rs2     = if_instr[15:11];
   assign imm_ext = {{(CPU_WIDTH-16){if_instr[15]}}, if_instr[15:0]};

   assign known_op  = (op inside {OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ});
   assign uses_rs2  = (op inside {OP_ADD, OP_SUB, OP_SW, OP_BEQ});
   assign writes_rd = (op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LW});

   // Load result is not available until after EX/MEM, so a dependent instruction waits one cycle.
   assign hazard = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                   ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2))) && if_valid;

   // Write-through read: a same-cycle writeback to the addressed register wins over the array.
   function automatic logic [CPU_WIDTH-1:0] rf_read(input logic [4:0] a);
      if (a == 5'd0)
         return '0;
      else if (wb_we && (wb_rd == a))
         return wb_data;
      else
         return rf_q[a];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (wb_we && (wb_rd != 5'd0)) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      ex_d     = '0;
      stall_if = 1'b0;
      if (rst) begin
         case (state_q)
            RUN: begin
               if (!branch_valid) begin
                  if (hazard) begin
                     stall_if = 1'b1;
                  end else if (if_valid) begin
                     if (op == OP_HALT) begin
                        state_d = HALTED;
                     end else begin
                        ex_d.valid     = 1'b1;
                        ex_d.op        = known_op ? op : OP_NOP;
                        ex_d.rd        = rd;
                        ex_d.rs1_val   = rf_read(rs1);
                        ex_d.rs2_val   = uses_rs2 ? rf_read(rs2) : '0;
                        ex_d.imm       = imm_ext;
                        ex_d.pc        = if_pc;
                        ex_d.we        = writes_rd && (rd != 5'd0);
                        ex_d.is_load   = (op == OP_LW);
                        ex_d.is_store  = (op == OP_SW);
                        ex_d.is_branch = (op == OP_BEQ);
                     end
                  end
               end
            end
            HALTED:  stall_if = 1'b1;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
         ex_q    <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
      end
   end

   assign halted       = (state_q == HALTED);
   assign ex_valid     = ex_q.valid;
   assign ex_op        = ex_q.op;
   assign ex_rd        = ex_q.rd;
   assign ex_rs1_val   = ex_q.rs1_val;
   assign ex_rs2_val   = ex_q.rs2_val;
   assign ex_imm       = ex_q.imm;
   assign ex_pc        = ex_q.pc;
   assign ex_we        = ex_q.we;
   assign ex_is_load   = ex_q.is_load;
   assign ex_is_store  = ex_q.is_store;
   assign ex_is_branch = ex_q.is_branch;

endmodule

// File: tb/tb_kamacore_stage_id.sv
// Bench for kamacore_stage_id: directed scenarios then randomized traffic, checked by a
// scoreboard fed from an instruction-level reference model.
module tb_kamacore_stage_id;

   localparam int W = 32;
   localparam int A = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] if_instr = '0;
   logic [A-1:0] if_pc = '0;
   logic         if_valid = 1'b0;
   logic         branch_valid = 1'b0;
   logic         wb_we = 1'b0;
   logic [4:0]   wb_rd = '0;
   logic [W-1:0] wb_data = '0;
   logic         stall_if, halted, ex_valid, ex_we, ex_is_load, ex_is_store, ex_is_branch;
   logic [5:0]   ex_op;
   logic [4:0]   ex_rd;
   logic [W-1:0] ex_rs1_val, ex_rs2_val, ex_imm;
   logic [A-1:0] ex_pc;

   kamacore_stage_id #(.CPU_WIDTH(W), .ADDR_WIDTH(A)) dut (
      .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .branch_valid(branch_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_if(stall_if), .halted(halted), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch)
   );

   // clock / reset
   always #5 clk = ~clk;

   // stall is the pre-edge value; everything else is what the edge should produce
   typedef struct packed {
      logic         stall;
      logic         halted;
      logic         exv;
      logic [5:0]   op;
      logic [4:0]   rd;
      logic [W-1:0] rs1v;
      logic [W-1:0] rs2v;
      logic [W-1:0] imm;
      logic [A-1:0] pc;
      logic         we;
      logic         ld;
      logic         st;
      logic         br;
   } exp_t;

   exp_t         exp_q[$];
   int           n_checks = 0;
   int           n_errors = 0;

   // reference model state
   logic [W-1:0] m_rf [32];
   logic         m_halted = 1'b0;
   exp_t         m_last = '0;
   int           m_halt_cycles = 0;

   function automatic logic [W-1:0] m_read(input logic [4:0] r);
      if (r == 0) return '0;
      if (wb_we && wb_rd == r) return wb_data;
      return m_rf[r];
   endfunction

   task automatic model_step();
      exp_t        e;
      logic [5:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic        uses2, haz;
      e   = '0;
      op  = if_instr[31:26];
      rd  = if_instr[25:21];
      rs1 = if_instr[20:16];
      rs2 = if_instr[15:11];
      if (!rst) begin
         m_halted = 1'b0;
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
      end else begin
         uses2 = (op == 6'h01 || op == 6'h02 || op == 6'h05 || op == 6'h06);
         haz = m_last.exv && m_last.ld && m_last.rd != 0 &&
               (m_last.rd == rs1 || (uses2 && m_last.rd == rs2)) && if_valid;
         if (m_halted) e.stall = 1'b1;
         else if (branch_valid) e.stall = 1'b0;
         else if (haz) e.stall = 1'b1;
         else if (if_valid) begin
            if (op == 6'h3F) m_halted = 1'b1;
            else begin
               e.exv  = 1'b1;
               e.op   = (op <= 6'h06) ? op : 6'h00;
               e.rd   = rd;
               e.rs1v = m_read(rs1);
               e.rs2v = uses2 ? m_read(rs2) : '0;
               e.imm  = W'($signed(if_instr[15:0]));
               e.pc   = if_pc;
               e.we   = (op >= 6'h01 && op <= 6'h04) && rd != 0;
               e.ld   = (op == 6'h04);
               e.st   = (op == 6'h05);
               e.br   = (op == 6'h06);
            end
         end
         if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
      end
      e.halted = m_halted;
      m_halt_cycles = m_halted ? m_halt_cycles + 1 : 0;
      m_last = e;
      exp_q.push_back(e);
   endtask

   // driver
   task automatic drive(input logic r, input logic [W-1:0] ins, input logic [A-1:0] pc,
                        input logic v, input logic b, input logic we, input logic [4:0] wrd,
                        input logic [W-1:0] wd);
      @(negedge clk);
      rst = r; if_instr = ins; if_pc = pc; if_valid = v; branch_valid = b;
      wb_we = we; wb_rd = wrd; wb_data = wd;
      model_step();
   endtask

   function automatic logic [W-1:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 11'd0};
   endfunction

   function automatic logic [W-1:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall_if", 64'(stall_if), 64'(e.stall));
            @(posedge clk);
            #1;
            chk("halted", 64'(halted), 64'(e.halted));
            chk("ex_valid", 64'(ex_valid), 64'(e.exv));
            chk("ex_op", 64'(ex_op), 64'(e.op));
            chk("ex_rd", 64'(ex_rd), 64'(e.rd));
            chk("ex_rs1_val", 64'(ex_rs1_val), 64'(e.rs1v));
            chk("ex_rs2_val", 64'(ex_rs2_val), 64'(e.rs2v));
            chk("ex_imm", 64'(ex_imm), 64'(e.imm));
            chk("ex_pc", 64'(ex_pc), 64'(e.pc));
            chk("ex_we", 64'(ex_we), 64'(e.we));
            chk("ex_is_load", 64'(ex_is_load), 64'(e.ld));
            chk("ex_is_store", 64'(ex_is_store), 64'(e.st));
            chk("ex_is_branch", 64'(ex_is_branch), 64'(e.br));
         end
      end
   end

   // stimulus
   initial begin
      logic [5:0]   ops [9];
      logic [W-1:0] ins;
      logic [A-1:0] pc;
      logic         v, r;
      ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h2A, 6'h3F};
      for (int i = 0; i < 32; i++) m_rf[i] = '0;

      drive(0, '0, '0, 0, 0, 0, 0, '0);
      drive(0, enc(6'h01, 5'd3, 5'd1, 5'd2), 10'd9, 1, 0, 1, 5'd9, 32'h77);
      // writeback then dependent ADD
      drive(1, '0, '0, 0, 0, 1, 5'd5, 32'h1234);
      drive(1, enc(6'h01, 5'd3, 5'd5, 5'd0), 10'd1, 1, 0, 0, 0, '0);
      drive(1, enc_i(6'h03, 5'd2, 5'd0, 16'hFFFE), 10'd2, 1, 0, 0, 0, '0);
      drive(1, enc(6'h2A, 5'd6, 5'd5, 5'd5), 10'd3, 1, 0, 0, 0, '0);
      // load-use: stall, bubble, then issue
      drive(1, enc_i(6'h04, 5'd4, 5'd5, 16'h0010), 10'd4, 1, 0, 0, 0, '0);
      drive(1, enc(6'h01, 5'd6, 5'd4, 5'd0), 10'd5, 1, 0, 0, 0, '0);
      drive(1, enc(6'h01, 5'd6, 5'd4, 5'd0), 10'd5, 1, 0, 0, 0, '0);
      // load-use squashed by a branch
      drive(1, enc_i(6'h04, 5'd4, 5'd5, 16'h0010), 10'd6, 1, 0, 0, 0, '0);
      drive(1, enc(6'h01, 5'd6, 5'd4, 5'd0), 10'd7, 1, 1, 0, 0, '0);
      // write-through on rs2, then r0 write is ignored
      drive(1, enc(6'h02, 5'd1, 5'd5, 5'd7), 10'd8, 1, 0, 1, 5'd7, 32'hAA);
      drive(1, enc(6'h01, 5'd1, 5'd0, 5'd0), 10'd9, 1, 0, 1, 5'd0, 32'h55);
      drive(1, enc(6'h05, 5'd7, 5'd0, 5'd7), 10'd10, 1, 0, 0, 0, '0);
      // HALT, writes while halted, then one reset edge
      drive(1, enc(6'h3F, 5'd0, 5'd0, 5'd0), 10'd11, 1, 0, 0, 0, '0);
      drive(1, enc(6'h01, 5'd2, 5'd5, 5'd7), 10'd12, 1, 0, 1, 5'd8, 32'h88);
      drive(1, enc(6'h01, 5'd2, 5'd5, 5'd7), 10'd12, 1, 0, 0, 0, '0);
      drive(0, enc(6'h01, 5'd2, 5'd5, 5'd7), 10'd12, 1, 0, 0, 0, '0);
      drive(1, enc(6'h01, 5'd2, 5'd5, 5'd8), 10'd13, 1, 0, 0, 0, '0);

      // random traffic; IF holds its instruction while stalled
      ins = '0; pc = '0; v = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!(m_last.stall && !m_halted)) begin
            ins = {ops[$urandom_range(0, ($urandom_range(0, 30) == 0) ? 8 : 7)],
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            pc  = A'($urandom);
            v   = ($urandom_range(0, 9) != 0);
         end
         r = !(m_halt_cycles > 4 || $urandom_range(0, 99) == 0);
         drive(r, ins, pc, v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
               5'($urandom_range(0, 7)), $urandom);
      end
      drive(1, '0, '0, 0, 0, 0, 0, '0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
